subcarrier_ctrl: RTL and testbench

Sequencer and configuration controller for the subcarrier generator that feeds external composite encoders. It owns PHASE_INC and subcarrier_enable, and switches video standards glitch-free: stop, clear the accumulator, load the increment, then settle. It optionally re-phases the subcarrier each frame. It also produces the line-timed burst gate and the PAL line-alternation flag that the encoder interface consumes.

---
 rtl/subcarrier_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_subcarrier_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subcarrier_ctrl.sv
// -----------------------------------------------------------------------------
// subcarrier_ctrl
//   Sequencer and configuration controller for the colour subcarrier generator.
//   Owns PHASE_INC / subcarrier_enable and switches video standards without
//   glitches (stop, clear accumulator, load increment, settle). Optionally
//   re-phases the subcarrier on every vsync rise, and produces the line-timed
//   colour-burst gate and the PAL V-switch flag.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cfg_valid/cfg_ready configuration handshake (ready only in OFF and RUN)
//   cfg_std             0=NTSC 1=PAL 2=custom (cfg_inc) 3=off
//   cfg_inc             custom 40-bit phase increment
//   cfg_frame_lock      re-phase on every vsync rising edge
//   hsync, vsync        active-high syncs, clk domain
//   PHASE_INC           increment to generator
//   subcarrier_enable   generator enable (low clears its accumulator)
//   locked              subcarrier running and settled
//   burst_gate          colour-burst window
//   pal_alt             PAL line-alternation flag
// -----------------------------------------------------------------------------
module subcarrier_ctrl #(
  parameter logic [39:0] INC_NTSC    = 40'd78715036989,
  parameter logic [39:0] INC_PAL     = 40'd97496307375,
  parameter int          SETTLE_CYC  = 64,
  parameter int          BURST_START = 40,
  parameter int          BURST_LEN   = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_std,
  input  logic [39:0] cfg_inc,
  input  logic        cfg_frame_lock,
  input  logic        hsync,
  input  logic        vsync,
  output logic [39:0] PHASE_INC,
  output logic        subcarrier_enable,
  output logic        locked,
  output logic        burst_gate,
  output logic        pal_alt
);

  localparam int          SETTLE_EFF  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_EFF - 1);
  localparam logic [11:0] BURST_ON    = 12'(BURST_START + 1);
  localparam logic [11:0] BURST_OFF   = 12'(BURST_START + BURST_LEN);
  localparam logic [1:0]  STD_NTSC    = 2'd0;
  localparam logic [1:0]  STD_PAL     = 2'd1;
  localparam logic [1:0]  STD_CUSTOM  = 2'd2;
  localparam logic [1:0]  STD_OFF     = 2'd3;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_STOP   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_std;
  logic [39:0] r_inc;
  logic        r_flock;
  logic        r_hs_d;
  logic        r_vs_d;
  logic [15:0] r_settle;
  logic [11:0] r_bcnt;
  logic        r_bact;
  logic [39:0] r_phase_inc;
  logic        r_en;
  logic        r_locked;
  logic        r_ready;
  logic        r_gate;
  logic        r_pal;

  logic        w_xfer;
  logic        w_hs_rise;
  logic        w_hs_fall;
  logic        w_vs_rise;
  logic        w_stay_run;
  logic        w_arm;
  logic        w_flock_kick;
  logic [11:0] w_bcnt_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  assign w_xfer       = cfg_valid & r_ready;
  assign w_hs_rise    = hsync & ~r_hs_d;
  assign w_hs_fall    = ~hsync & r_hs_d;
  assign w_vs_rise    = vsync & ~r_vs_d;
  // Staying in RUN this cycle: a simultaneous cfg transfer overrides line/frame work.
  assign w_stay_run   = (r_state == S_RUN) && (w_next == S_RUN);
  assign w_arm        = w_stay_run && (r_std != STD_OFF);
  assign w_flock_kick = w_stay_run && r_flock && w_vs_rise;
  assign w_bcnt_inc   = sat_inc12(r_bcnt);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_OFF;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:    if (w_xfer) w_next = S_STOP;
      S_STOP:   w_next = S_LOAD;
      S_LOAD:   w_next = (r_std == STD_OFF) ? S_OFF : S_SETTLE;
      S_SETTLE: if (r_settle >= SETTLE_LAST) w_next = S_RUN;
      S_RUN:    if (w_xfer) w_next = S_STOP;
      default:  w_next = S_OFF;
    endcase
  end

  // Configuration latch and sync history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_std   <= STD_NTSC;
      r_inc   <= '0;
      r_flock <= 1'b0;
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_std   <= cfg_std;
        r_inc   <= cfg_inc;
        r_flock <= cfg_frame_lock;
      end
      r_hs_d <= hsync;
      r_vs_d <= vsync;
    end
  end

  // Settle counter: zero outside SETTLE, so it always starts from 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_settle <= '0;
    else if (r_state != S_SETTLE) r_settle <= '0;
    else                         r_settle <= sat_inc16(r_settle);
  end

  // Increment is only rewritten while enable is already low, so the generator
  // never sees a partially updated value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase_inc <= '0;
    end else if (r_state == S_STOP) begin
      case (r_std)
        STD_NTSC:   r_phase_inc <= INC_NTSC;
        STD_PAL:    r_phase_inc <= INC_PAL;
        STD_CUSTOM: r_phase_inc <= r_inc;
        default:    r_phase_inc <= '0;
      endcase
    end
  end

  // Control outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_locked <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_en     <= ((w_next == S_SETTLE) || (w_next == S_RUN)) && !w_flock_kick;
      r_locked <= (w_next == S_RUN);
      r_ready  <= (w_next == S_OFF) || (w_next == S_RUN);
    end
  end

  // PAL V-switch: vsync rise has priority over hsync rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_pal <= 1'b0;
    else if (!(w_stay_run && r_std == STD_PAL)) r_pal <= 1'b0;
    else if (w_vs_rise)                      r_pal <= 1'b0;
    else if (w_hs_rise)                      r_pal <= ~r_pal;
  end

  // Burst window: r_bcnt holds cycles elapsed since the last hsync fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
      r_bact <= 1'b0;
      r_gate <= 1'b0;
    end else if (!w_arm) begin
      r_bcnt <= '0;
      r_bact <= 1'b0;
      r_gate <= 1'b0;
    end else if (w_hs_fall) begin
      r_bcnt <= 12'd1;
      r_bact <= 1'b1;
      r_gate <= (BURST_ON == 12'd1);
    end else if (r_bact) begin
      r_bcnt <= w_bcnt_inc;
      r_bact <= (w_bcnt_inc < BURST_OFF);
      r_gate <= (w_bcnt_inc >= BURST_ON) && (w_bcnt_inc <= BURST_OFF);
    end else begin
      r_gate <= 1'b0;
    end
  end

  assign PHASE_INC         = r_phase_inc;
  assign subcarrier_enable = r_en;
  assign locked            = r_locked;
  assign cfg_ready         = r_ready;
  assign burst_gate        = r_gate;
  assign pal_alt           = r_pal;

endmodule

// File: tb/tb_subcarrier_ctrl.sv
// -----------------------------------------------------------------------------
// tb_subcarrier_ctrl
//   Scoreboard bench for subcarrier_ctrl. The stimulus process computes the
//   expected outputs of each cycle from a time-based reference model (transfer
//   time, latched standard, last hsync fall time) and queues them; a monitor
//   on the falling clock edge pops and compares.
// -----------------------------------------------------------------------------
module tb_subcarrier_ctrl;
  localparam logic [39:0] INC_NTSC    = 40'd78715036989;
  localparam logic [39:0] INC_PAL     = 40'd97496307375;
  localparam int          SETTLE_CYC  = 4;
  localparam int          BURST_START = 40;
  localparam int          BURST_LEN   = 200;
  localparam int          S_EFF       = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;

  logic        clk = 1'b1;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_std;
  logic [39:0] cfg_inc;
  logic        cfg_frame_lock;
  logic        hsync;
  logic        vsync;
  logic [39:0] PHASE_INC;
  logic        subcarrier_enable;
  logic        locked;
  logic        burst_gate;
  logic        pal_alt;

  always #5 clk = ~clk;

  subcarrier_ctrl #(
    .INC_NTSC   (INC_NTSC),
    .INC_PAL    (INC_PAL),
    .SETTLE_CYC (SETTLE_CYC),
    .BURST_START(BURST_START),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_std          (cfg_std),
    .cfg_inc          (cfg_inc),
    .cfg_frame_lock   (cfg_frame_lock),
    .hsync            (hsync),
    .vsync            (vsync),
    .PHASE_INC        (PHASE_INC),
    .subcarrier_enable(subcarrier_enable),
    .locked           (locked),
    .burst_gate       (burst_gate),
    .pal_alt          (pal_alt)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [39:0] inc;
    logic        en;
    logic        lk;
    logic        rdy;
    logic        bg;
    logic        pa;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;
  int   cur      = 0;

  // Reference model state (time-based)
  bit          m_have;
  int          m_tx;
  logic [1:0]  m_std;
  logic [39:0] m_inc_new;
  logic [39:0] m_inc_old;
  bit          m_fl;
  bit          m_pal;
  bit          m_flp;
  bit          m_bv;
  int          m_tf;
  logic        m_hs_p;
  logic        m_vs_p;
  bit          last_xfer;

  function automatic logic [39:0] inc_of(input logic [1:0] s, input logic [39:0] ci);
    case (s)
      2'd0:    return INC_NTSC;
      2'd1:    return INC_PAL;
      2'd2:    return ci;
      default: return 40'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_have = 0; m_tx = 0; m_std = 2'd0; m_inc_new = '0; m_inc_old = '0; m_fl = 0;
    m_pal = 0; m_flp = 0; m_bv = 0; m_tf = 0; m_hs_p = 1'b0; m_vs_p = 1'b0;
  endtask

  // One clock cycle: expected outputs of cycle t, then fold in cycle t inputs.
  task automatic tick();
    exp_t e;
    bit   run, xfer, hsr, hsf, vsr;
    int   d;
    e.cyc = 32'(t);
    if (reset) begin
      model_reset();
      e.inc = '0; e.en = 0; e.lk = 0; e.rdy = 1; e.bg = 0; e.pa = 0;
      last_xfer = 0;
    end else begin
      run   = m_have && (m_std != 2'd3) && (t >= m_tx + 3 + S_EFF);
      e.inc = (m_have && t >= m_tx + 2) ? m_inc_new : m_inc_old;
      e.en  = m_have && (m_std != 2'd3) && (t >= m_tx + 3) && !m_flp;
      e.lk  = run;
      e.rdy = !m_have || ((m_std == 2'd3) ? (t >= m_tx + 3) : run);
      d     = t - m_tf;
      e.bg  = m_bv && (d >= BURST_START + 1) && (d <= BURST_START + BURST_LEN);
      e.pa  = m_pal;

      xfer = cfg_valid && e.rdy;
      hsr  = hsync && !m_hs_p;
      hsf  = !hsync && m_hs_p;
      vsr  = vsync && !m_vs_p;
      if (run && !xfer && m_std == 2'd1) m_pal = vsr ? 1'b0 : (hsr ? !m_pal : m_pal);
      else                               m_pal = 1'b0;
      m_flp = run && !xfer && m_fl && vsr;
      if (!run || xfer)                     m_bv = 0;
      else if (hsf && m_std != 2'd3) begin  m_bv = 1; m_tf = t; end
      if (xfer) begin
        m_inc_old = e.inc;
        m_have    = 1;
        m_tx      = t;
        m_std     = cfg_std;
        m_inc_new = inc_of(cfg_std, cfg_inc);
        m_fl      = cfg_frame_lock;
      end
      m_hs_p    = hsync;
      m_vs_p    = vsync;
      last_xfer = xfer;
    end
    if (t > 0) sb_q.push_back(e);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_req(input logic [1:0] s, input logic [39:0] ci, input logic fl);
    int n;
    n = 0;
    cfg_valid = 1; cfg_std = s; cfg_inc = ci; cfg_frame_lock = fl;
    do begin
      tick();
      n++;
    end while (!last_xfer && n < 100);
    if (!last_xfer) begin
      failures++;
      $display("FAIL cfg_handshake no transfer within %0d cycles (std=%0d)", n, s);
    end
    cfg_valid = 0;
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cur, act, expv);
    end
  endtask

  always @(posedge clk) cur <= cur + 1;

  exp_t me;
  always @(negedge clk) begin
    while (sb_q.size() != 0 && int'(sb_q[0].cyc) < cur) begin
      me = sb_q.pop_front();
      failures++;
      $display("FAIL stale_entry cyc=%0d got=none expected=cycle %0d", cur, me.cyc);
    end
    if (sb_q.size() != 0 && int'(sb_q[0].cyc) == cur) begin
      me = sb_q.pop_front();
      chk("PHASE_INC",         PHASE_INC,                me.inc);
      chk("subcarrier_enable", {39'd0, subcarrier_enable}, {39'd0, me.en});
      chk("locked",            {39'd0, locked},          {39'd0, me.lk});
      chk("cfg_ready",         {39'd0, cfg_ready},       {39'd0, me.rdy});
      chk("burst_gate",        {39'd0, burst_gate},      {39'd0, me.bg});
      chk("pal_alt",           {39'd0, pal_alt},         {39'd0, me.pa});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp, llen, vc, rc;
    reset = 1; cfg_valid = 0; cfg_std = 0; cfg_inc = 0; cfg_frame_lock = 0;
    hsync = 0; vsync = 0;
    model_reset();
    last_xfer = 0;
    idle(3);
    reset = 0;

    // NTSC bring-up, then switch to PAL while running
    cfg_req(2'd0, 40'd0, 1'b0);
    idle(12);
    cfg_req(2'd1, 40'd0, 1'b0);
    idle(10);

    // Five hsync pulses, then vsync rising together with a sixth hsync
    repeat (5) begin hsync = 1; idle(3); hsync = 0; idle(5); end
    hsync = 1; vsync = 1; idle(3); hsync = 0; vsync = 0; idle(5);

    // Burst window and restart by a second fall 100 cycles later
    hsync = 1; idle(4); hsync = 0; idle(96); hsync = 1; idle(4); hsync = 0; idle(300);

    // Frame lock re-phase, then a vsync rise coinciding with a transfer
    cfg_req(2'd0, 40'd0, 1'b1);
    idle(10);
    vsync = 1; idle(3); vsync = 0; idle(5);
    vsync = 1; cfg_valid = 1; cfg_std = 2'd1; cfg_frame_lock = 1;
    tick();
    cfg_valid = 0;
    idle(3); vsync = 0; idle(10);

    // Reset in the middle of SETTLE, then turn the subcarrier off
    cfg_req(2'd2, 40'h12_3456_789A, 1'b0);
    idle(2);
    reset = 1; idle(2); reset = 0;
    cfg_req(2'd3, 40'd0, 1'b0);
    idle(10);

    // Randomized traffic
    lp = 0; llen = 200; vc = 0; rc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rc > 0) begin reset = 1; rc--; end
      else begin reset = 0; if ($urandom_range(0, 1999) == 0) rc = 2; end
      if (cfg_valid && last_xfer) cfg_valid = 0;
      if (!cfg_valid && $urandom_range(0, 179) == 0) begin
        cfg_valid      = 1;
        cfg_std        = 2'($urandom_range(0, 3));
        cfg_inc        = {8'($urandom), 32'($urandom)};
        cfg_frame_lock = 1'($urandom_range(0, 1));
      end
      hsync = (lp < 6);
      lp++;
      if (lp >= llen) begin lp = 0; llen = $urandom_range(60, 420); end
      if (vc > 0) vc--;
      else if ($urandom_range(0, 349) == 0) vc = 3;
      vsync = (vc > 0);
      tick();
    end
    reset = 0; cfg_valid = 0; hsync = 0; vsync = 0;
    idle(20);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
